// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU program-loading path: loader FSM encoding,
// frame marker, timeout default and the running-checksum helper.
package cpu_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CNT_HI = 3'd1;
  localparam logic [2:0] ST_CNT_LO = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_CHECK  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ERR    = 3'd6;

  localparam logic [7:0] START_BYTE_DEF = 8'hA5;
  localparam int         TIMEOUT_DEF    = 1000;

  function automatic logic [7:0] csum_add(input logic [7:0] csum, input logic [7:0] data);
    return csum ^ data;
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses framed words into instruction memory
// writes and holds the CPU in reset until a load completes with a good checksum.
module prog_loader
  import cpu_pkg::*;
#(
  parameter int         ADDR_W     = 10,
  parameter logic [7:0] START_BYTE = START_BYTE_DEF,
  parameter int         TIMEOUT    = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int          IDLE_W    = $clog2(TIMEOUT + 1);
  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

  logic [2:0]        state_r;
  logic [15:0]       cnt_r;
  logic [ADDR_W-1:0] widx_r;
  logic [1:0]        bidx_r;
  logic [23:0]       asm_r;
  logic [7:0]        csum_r;
  logic [IDLE_W-1:0] idle_r;
  logic              rx_ready_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [31:0]       mem_wdata_r;
  logic              cpu_hold_r;
  logic              done_r;
  logic              error_r;

  logic              accept_s;
  logic              in_frame_s;
  logic              timeout_s;
  logic              last_word_s;
  logic              count_bad_s;
  logic [15:0]       count_s;

  assign accept_s    = rx_valid & rx_ready_r;
  assign in_frame_s  = (state_r == ST_CNT_HI) || (state_r == ST_CNT_LO) ||
                       (state_r == ST_DATA)   || (state_r == ST_CHECK);
  assign timeout_s   = (32'(idle_r) + 32'd1) >= 32'(TIMEOUT);
  assign last_word_s = 32'(widx_r) == (32'(cnt_r) - 32'd1);
  assign count_s     = {cnt_r[15:8], rx_data};
  assign count_bad_s = (count_s == 16'd0) || ({1'b0, count_s} > MAX_WORDS);

  assign rx_ready  = rx_ready_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign cpu_hold  = cpu_hold_r;
  assign done      = done_r;
  assign error     = error_r;

  // Frame parser, word assembly, write strobe and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 16'd0;
      widx_r      <= {ADDR_W{1'b0}};
      bidx_r      <= 2'd0;
      asm_r       <= 24'd0;
      csum_r      <= 8'd0;
      idle_r      <= {IDLE_W{1'b0}};
      rx_ready_r  <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= 32'd0;
      cpu_hold_r  <= 1'b1;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      mem_we_r   <= 1'b0;
      rx_ready_r <= 1'b1;
      if (in_frame_s && !accept_s) begin
        idle_r <= idle_r + IDLE_W'(1);
      end else begin
        idle_r <= {IDLE_W{1'b0}};
      end

      case (state_r)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (accept_s && (rx_data == START_BYTE)) begin
            state_r    <= ST_CNT_HI;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            cpu_hold_r <= 1'b1;
            widx_r     <= {ADDR_W{1'b0}};
            bidx_r     <= 2'd0;
            csum_r     <= 8'd0;
          end else begin
            state_r <= state_r;
          end
        end
        ST_CNT_HI: begin
          if (accept_s) begin
            cnt_r[15:8] <= rx_data;
            state_r     <= ST_CNT_LO;
          end else if (timeout_s) begin
            state_r <= ST_ERR;
            error_r <= 1'b1;
          end else begin
            state_r <= state_r;
          end
        end
        ST_CNT_LO: begin
          if (accept_s) begin
            cnt_r <= count_s;
            if (count_bad_s) begin
              state_r <= ST_ERR;
              error_r <= 1'b1;
            end else begin
              state_r <= ST_DATA;
            end
          end else if (timeout_s) begin
            state_r <= ST_ERR;
            error_r <= 1'b1;
          end else begin
            state_r <= state_r;
          end
        end
        ST_DATA: begin
          // The strobe cycle advances the word index; the final word stays put so no wrap occurs.
          if (mem_we_r) begin
            if (last_word_s) begin
              state_r <= ST_CHECK;
            end else begin
              widx_r <= widx_r + ADDR_W'(1);
            end
          end else if (accept_s) begin
            csum_r <= csum_add(csum_r, rx_data);
            asm_r  <= {asm_r[15:0], rx_data};
            bidx_r <= bidx_r + 2'd1;
            if (bidx_r == 2'd3) begin
              mem_we_r    <= 1'b1;
              rx_ready_r  <= 1'b0;
              mem_addr_r  <= widx_r;
              mem_wdata_r <= {asm_r, rx_data};
            end else begin
              mem_we_r <= 1'b0;
            end
          end else if (timeout_s) begin
            state_r <= ST_ERR;
            error_r <= 1'b1;
          end else begin
            state_r <= state_r;
          end
        end
        ST_CHECK: begin
          if (accept_s) begin
            if (rx_data == csum_r) begin
              state_r    <= ST_DONE;
              done_r     <= 1'b1;
              cpu_hold_r <= 1'b0;
            end else begin
              state_r <= ST_ERR;
              error_r <= 1'b1;
            end
          end else if (timeout_s) begin
            state_r <= ST_ERR;
            error_r <= 1'b1;
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes and end-of-frame status
// are queued by the stimulus and popped by an independent output monitor.
module tb_prog_loader;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int  vectors = 0;
  int  miscompares = 0;
  wr_t exp_wr[$];
  logic [2:0] exp_st[$];

  localparam logic [2:0] ST_OK  = 3'b100;  // {done, error, cpu_hold}
  localparam logic [2:0] ST_BAD = 3'b011;

  prog_loader dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: pops a write per strobe and a status per newly raised done/error.
  initial begin : monitor
    logic fin;
    logic prev_fin;
    wr_t  w;
    logic [2:0] s;
    prev_fin = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (mem_we) begin
          check("rx_ready_during_we", {63'd0, rx_ready}, 64'd0);
          if (exp_wr.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
          end else begin
            w = exp_wr.pop_front();
            check("wr_addr", {54'd0, mem_addr}, {54'd0, w.addr});
            check("wr_data", {32'd0, mem_wdata}, {32'd0, w.data});
          end
        end
        if (done && error) check("done_error_exclusive", 64'd1, 64'd0);
        fin = done | error;
        if (fin && !prev_fin) begin
          if (exp_st.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_status: got %b expected none", {done, error, cpu_hold});
          end else begin
            s = exp_st.pop_front();
            check("status", {61'd0, done, error, cpu_hold}, {61'd0, s});
          end
        end
        prev_fin = fin;
      end else begin
        prev_fin = 1'b0;
      end
    end
  end

  task automatic send_list(input byte_q_t q, input bit gap);
    int n;
    foreach (q[i]) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = q[i];
      n = 0;
      while (!rx_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!rx_ready) begin
        vectors++;
        miscompares++;
        $display("FAIL byte_stall: got rx_ready 0 expected 1 within 50 cycles");
      end
      @(posedge clk);
      if (gap) begin
        @(negedge clk);
        rx_valid = 1'b0;
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_st.size() != 0 || exp_wr.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 64'(exp_st.size() + exp_wr.size()), 64'd0);
    exp_st.delete();
    exp_wr.delete();
    repeat (3) @(negedge clk);
  endtask

  // 00^43^08^00^00^A6^20^00 = CD
  task automatic frame_a(input logic [7:0] chk, input bit gap, input logic [2:0] st);
    exp_wr.push_back('{addr: 10'd0, data: 32'h0043_0800});
    exp_wr.push_back('{addr: 10'd1, data: 32'h00A6_2000});
    exp_st.push_back(st);
    send_list('{8'hA5, 8'h00, 8'h02, 8'h00, 8'h43, 8'h08, 8'h00,
                8'h00, 8'hA6, 8'h20, 8'h00, chk}, gap);
    drain(100);
  endtask

  task automatic check_reset_vals();
    check("rst_rx_ready", {63'd0, rx_ready}, 64'd0);
    check("rst_mem_we", {63'd0, mem_we}, 64'd0);
    check("rst_mem_addr", {54'd0, mem_addr}, 64'd0);
    check("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
    check("rst_cpu_hold", {63'd0, cpu_hold}, 64'd1);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_error", {63'd0, error}, 64'd0);
  endtask

  initial begin : stim
    byte_q_t     big;
    logic [7:0]  chk;
    logic [31:0] w;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals();
    reset = 1'b0;
    @(negedge clk);
    check("idle_rx_ready", {63'd0, rx_ready}, 64'd1);
    check("idle_cpu_hold", {63'd0, cpu_hold}, 64'd1);

    frame_a(8'hCD, 1'b1, ST_OK);
    check("after_good_cpu_hold", {63'd0, cpu_hold}, 64'd0);
    frame_a(8'h00, 1'b1, ST_BAD);

    exp_st.push_back(ST_BAD);
    send_list('{8'hA5, 8'h00, 8'h00, 8'h12, 8'h34}, 1'b1);
    drain(50);
    exp_st.push_back(ST_BAD);
    send_list('{8'hA5, 8'h04, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44}, 1'b1);
    drain(50);

    exp_st.push_back(ST_BAD);
    send_list('{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34}, 1'b1);
    drain(1200);
    frame_a(8'hCD, 1'b1, ST_OK);

    // START_BYTE inside a frame is payload: A5^A5^00^01 = 01
    exp_wr.push_back('{addr: 10'd0, data: 32'hA5A5_0001});
    exp_st.push_back(ST_OK);
    send_list('{8'hA5, 8'h00, 8'h01, 8'hA5, 8'hA5, 8'h00, 8'h01, 8'h01}, 1'b1);
    drain(50);

    send_list('{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34}, 1'b1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals();
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("post_reset_no_write", 64'(exp_wr.size()), 64'd0);
    frame_a(8'hCD, 1'b1, ST_OK);

    frame_a(8'hCD, 1'b0, ST_OK);

    big = '{8'hA5, 8'h04, 8'h00};
    chk = 8'h00;
    for (int i = 0; i < 1024; i++) begin
      w = {8'(i), 8'(i >> 8), 8'h5A, ~8'(i)};
      exp_wr.push_back('{addr: 10'(i), data: w});
      for (int b = 3; b >= 0; b--) begin
        big.push_back(w[b*8 +: 8]);
        chk = chk ^ w[b*8 +: 8];
      end
    end
    big.push_back(chk);
    exp_st.push_back(ST_OK);
    send_list(big, 1'b0);
    drain(100);
    check("last_addr", {54'd0, mem_addr}, 64'h3FF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
